mux4_1_reg: RTL and testbench

//   4-to-1 selector for WIDTH-bit data words with a registered output.

---
 rtl/mux4_1_reg.sv | 82 ++++++++
 tb/tb_mux4_1_reg.sv | 134 +++++++++++++
 2 files changed

// File: rtl/mux4_1_reg.sv
// mux4_1_reg: 4-to-1 selector for WIDTH-bit words with a registered output.
//
// One of i0..i3 is picked by the 2-bit select s and appears on o one clock
// later. o_valid flags an edge on which o was loaded. o_par carries the even
// parity of o when the build defines MUX4_1_PARITY_EN; otherwise it is
// tied low, so the port list is the same in both builds.
//
// Parameters:
//   WIDTH   data width of i0..i3 and o (>= 1)
//
// Ports:
//   clk      in   rising-edge clock, the only clock
//   rst      in   synchronous active-high reset, takes priority over en
//   en       in   capture enable: 1 = load the selected word on this edge
//   i0..i3   in   data words, selected by s == 00, 01, 10, 11
//   s        in   select code
//   o        out  registered selected word, held while en == 0
//   o_valid  out  1 = o was loaded on the previous edge
//   o_par    out  even parity of o (MUX4_1_PARITY_EN), else constant 0
//
// Configuration macro: MUX4_1_PARITY_EN

module mux4_1_reg #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    input  logic [1:0]       s,
    output logic [WIDTH-1:0] o,
    output logic             o_valid,
    output logic             o_par
);

    logic [WIDTH-1:0] sel_d;

    // All four select codes are legal, so the case is complete as written.
    always_comb begin
        sel_d = i0;
        unique case (s)
            2'b00: sel_d = i0;
            2'b01: sel_d = i1;
            2'b10: sel_d = i2;
            2'b11: sel_d = i3;
        endcase
    end

`ifdef MUX4_1_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            o       <= '0;
            o_valid <= 1'b0;
            o_par   <= 1'b0;
        end else begin
            o_valid <= en;
            if (en) begin
                o     <= sel_d;
                o_par <= ^sel_d;
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            o       <= '0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= en;
            if (en) begin
                o <= sel_d;
            end
        end
    end

    assign o_par = 1'b0;
`endif

endmodule

// File: tb/tb_mux4_1_reg.sv
// Directed bench for mux4_1_reg: a WIDTH=2 and a WIDTH=8 instance share
// clock, reset, enable and select, and are checked after each edge.

module tb_mux4_1_reg;

`ifdef MUX4_1_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, en;
    logic [1:0] s;
    logic [1:0] a0, a1, a2, a3, ao;
    logic       a_valid, a_par;
    logic [7:0] b0, b1, b2, b3, bo;
    logic       b_valid, b_par;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mux4_1_reg #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .en(en),
        .i0(a0), .i1(a1), .i2(a2), .i3(a3), .s(s),
        .o(ao), .o_valid(a_valid), .o_par(a_par)
    );

    mux4_1_reg #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .en(en),
        .i0(b0), .i1(b1), .i2(b2), .i3(b3), .s(s),
        .o(bo), .o_valid(b_valid), .o_par(b_par)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected parity: the hand value when the feature is built, else 0.
    function automatic logic ep(input logic p);
        return PAR_ON ? p : 1'b0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check2(input string tag, input logic [1:0] o_e, input logic v_e,
                          input logic p_e);
        check({tag, "_o2"}, {6'd0, ao}, {6'd0, o_e});
        check({tag, "_v2"}, {7'd0, a_valid}, {7'd0, v_e});
        check({tag, "_p2"}, {7'd0, a_par}, {7'd0, ep(p_e)});
    endtask

    task automatic check8(input string tag, input logic [7:0] o_e, input logic v_e,
                          input logic p_e);
        check({tag, "_o8"}, bo, o_e);
        check({tag, "_v8"}, {7'd0, b_valid}, {7'd0, v_e});
        check({tag, "_p8"}, {7'd0, b_par}, {7'd0, ep(p_e)});
    endtask

    initial begin
        // Reset held two edges with live inputs and en=1.
        rst = 1'b1; en = 1'b1; s = 2'b11;
        a0 = 2'b00; a1 = 2'b01; a2 = 2'b10; a3 = 2'b11;
        b0 = 8'hA5; b1 = 8'h3C; b2 = 8'hFF; b3 = 8'h00;
        tick();
        check2("rst1", 2'b00, 1'b0, 1'b0);
        check8("rst1", 8'h00, 1'b0, 1'b0);
        tick();
        check2("rst2", 2'b00, 1'b0, 1'b0);
        check8("rst2", 8'h00, 1'b0, 1'b0);

        // Select sweep, one word per edge.
        rst = 1'b0; s = 2'b00;
        tick();
        check2("sw00", 2'b00, 1'b1, 1'b0);
        check8("sw00", 8'hA5, 1'b1, 1'b0);
        s = 2'b01;
        tick();
        check2("sw01", 2'b01, 1'b1, 1'b1);
        check8("sw01", 8'h3C, 1'b1, 1'b0);
        s = 2'b10;
        tick();
        check2("sw10", 2'b10, 1'b1, 1'b1);
        check8("sw10", 8'hFF, 1'b1, 1'b0);
        s = 2'b11;
        tick();
        check2("sw11", 2'b11, 1'b1, 1'b0);
        check8("sw11", 8'h00, 1'b1, 1'b0);

        // Load s=10, then hold with en=0 while s and i2 change.
        s = 2'b10;
        tick();
        check2("ld10", 2'b10, 1'b1, 1'b1);
        en = 1'b0; s = 2'b01; a2 = 2'b00; b2 = 8'h00;
        tick();
        check2("hold1", 2'b10, 1'b0, 1'b1);
        check8("hold1", 8'hFF, 1'b0, 1'b0);
        tick();
        check2("hold2", 2'b10, 1'b0, 1'b1);

        // Reset wins over en.
        en = 1'b1; s = 2'b11; rst = 1'b1;
        tick();
        check2("rst_en", 2'b00, 1'b0, 1'b0);
        check8("rst_en", 8'h00, 1'b0, 1'b0);
        rst = 1'b0;

        // Odd-popcount word on the wide instance.
        b1 = 8'h01; s = 2'b01;
        tick();
        check8("par01", 8'h01, 1'b1, 1'b1);

        // Glitch s within one cycle; only the value at the edge counts.
        s = 2'b00;
        #2 s = 2'b11;
        #2 s = 2'b00;
        tick();
        check2("glitch", 2'b00, 1'b1, 1'b0);
        check8("glitch", 8'hA5, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
